// File: rtl/night_rider_pkg.sv
// -----------------------------------------------------------------------------
// night_rider_pkg
//   Shared encodings for the Night Rider LED scanner:
//     - scan-mode encodings for the 2-bit mode input
//     - FSM state encoding (IDLE / RUN / DONE)
//     - norm_mode(): folds the reserved mode onto bounce at capture time so
//       the step logic only ever sees the three real patterns.
// -----------------------------------------------------------------------------
package night_rider_pkg;

    typedef logic [1:0] mode_t;
    typedef logic [1:0] state_t;

    // Scan pattern encodings
    localparam mode_t MODE_BOUNCE    = 2'b00;
    localparam mode_t MODE_WRAP_UP   = 2'b01;
    localparam mode_t MODE_WRAP_DOWN = 2'b10;
    localparam mode_t MODE_RESERVED  = 2'b11;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The reserved pattern runs exactly like bounce.
    function automatic mode_t norm_mode(input mode_t m);
        return (m == MODE_RESERVED) ? MODE_BOUNCE : m;
    endfunction

endpackage

// File: rtl/night_rider_prescaler.sv
// -----------------------------------------------------------------------------
// night_rider_prescaler
//   Step-rate divider. While enabled, counts 0..period and raises tick for the
//   single cycle in which the count equals period, then restarts at 0. A step
//   therefore happens every period+1 cycles; period = 0 ticks every cycle.
//
// Ports
//   clk     in   clock (rising edge)
//   rst_n   in   asynchronous active-low reset
//   clr     in   synchronous clear of the count (held while not running so
//                the first tick of a run lands period+1 cycles after entry)
//   en      in   count enable
//   period  in   [PW-1:0] terminal count (step interval minus one)
//   tick    out  combinational; high when enabled and count == period
// -----------------------------------------------------------------------------
module night_rider_prescaler
    import night_rider_pkg::*;
#(
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [PW-1:0] period,
    output logic          tick
);

    logic [PW-1:0] cnt_reg;
    logic [PW-1:0] cnt_next;

    assign tick = en && (cnt_reg == period);

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = tick ? '0 : cnt_reg + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/night_rider_ctrl.sv
// -----------------------------------------------------------------------------
// night_rider_ctrl
//   "Night Rider" LED scanner. A start request captures mode, period and pass
//   count, then a single lit LED walks across N positions, one step per
//   prescaler tick, in one of three patterns:
//     bounce     0,1..N-1,N-2..0,1..   (no dwell at the ends)
//     wrap-up    0,1..N-1,0,1..
//     wrap-down  N-1..0,N-1..
//   A pass ends on the step that lands on 0 (bounce), N-1->0 (wrap-up) or
//   0->N-1 (wrap-down). After the requested number of passes the FSM spends
//   one cycle in DONE (done pulse) and returns to IDLE. passes = 0 runs until
//   stop. stop aborts a run with no done pulse and leaves pos where it was.
//
// Ports
//   clk      in   clock (rising edge)
//   rst_n    in   asynchronous active-low reset
//   start    in   begin a run (honoured only in IDLE, and only without stop)
//   stop     in   abort request (honoured only in RUN, beats everything)
//   mode     in   [1:0] scan pattern, see night_rider_pkg
//   period   in   [PW-1:0] step interval minus one, in clk cycles
//   passes   in   [PASS_W-1:0] passes to run, 0 = endless
//   busy     out  high in RUN
//   done     out  one-cycle pulse at normal completion
//   pos      out  [clog2(N)-1:0] current lit position
//   led_out  out  [N-1:0] one-hot LED drive, dark in IDLE
// -----------------------------------------------------------------------------
module night_rider_ctrl
    import night_rider_pkg::*;
#(
    parameter int N      = 8,
    parameter int PW     = 16,
    parameter int PASS_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [1:0]           mode,
    input  logic [PW-1:0]        period,
    input  logic [PASS_W-1:0]    passes,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(N)-1:0] pos,
    output logic [N-1:0]         led_out
);

    localparam int                POS_W    = $clog2(N);
    localparam logic [POS_W-1:0]  POS_LAST = POS_W'(N - 1);
    localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]        state_reg,    state_next;
    mode_t             mode_reg,     mode_next;
    logic [PW-1:0]     period_reg,   period_next;
    logic [PASS_W-1:0] passes_reg,   passes_next;
    logic [PASS_W-1:0] pass_cnt_reg, pass_cnt_next;
    logic [POS_W-1:0]  pos_reg,      pos_next;
    logic              dir_up_reg,   dir_up_next;

    // -------------------------------------------------------------------------
    // Prescaler: held clear whenever we are not running, so every run starts
    // from a zero count.
    // -------------------------------------------------------------------------
    logic tick;

    night_rider_prescaler #(
        .PW (PW)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_reg != ST_RUN),
        .en     (state_reg == ST_RUN),
        .period (period_reg),
        .tick   (tick)
    );

    // -------------------------------------------------------------------------
    // Candidate next position for one step in the captured pattern, plus a
    // flag saying this step completes a pass.
    // -------------------------------------------------------------------------
    logic [POS_W-1:0] step_pos;
    logic             step_dir_up;
    logic             step_pass;

    always_comb begin
        step_pos    = pos_reg;
        step_dir_up = dir_up_reg;
        step_pass   = 1'b0;
        case (mode_reg)
            MODE_WRAP_UP: begin
                if (pos_reg == POS_LAST) begin
                    step_pos  = '0;
                    step_pass = 1'b1;
                end else begin
                    step_pos = pos_reg + POS_ONE;
                end
            end
            MODE_WRAP_DOWN: begin
                if (pos_reg == '0) begin
                    step_pos  = POS_LAST;
                    step_pass = 1'b1;
                end else begin
                    step_pos = pos_reg - POS_ONE;
                end
            end
            default: begin
                // Bounce: the turn-around itself is a step (no dwell). A pass
                // ends whenever a downward step lands on 0; with N = 2 that
                // downward step is the turn at the top, hence the shared
                // pos_reg == 1 test on both downward branches.
                if (dir_up_reg) begin
                    if (pos_reg == POS_LAST) begin
                        step_pos    = pos_reg - POS_ONE;
                        step_dir_up = 1'b0;
                        step_pass   = (pos_reg == POS_ONE);
                    end else begin
                        step_pos = pos_reg + POS_ONE;
                    end
                end else begin
                    if (pos_reg == '0) begin
                        step_pos    = POS_ONE;
                        step_dir_up = 1'b1;
                    end else begin
                        step_pos  = pos_reg - POS_ONE;
                        step_pass = (pos_reg == POS_ONE);
                    end
                end
            end
        endcase
    end

    // Pass counter: wraps silently in endless mode (passes_reg == 0).
    logic [PASS_W-1:0] pass_cnt_inc;
    logic              last_pass;

    assign pass_cnt_inc = pass_cnt_reg + PASS_W'(1);
    assign last_pass    = (passes_reg != '0) && (pass_cnt_inc == passes_reg);

    // -------------------------------------------------------------------------
    // FSM and datapath next-state
    // -------------------------------------------------------------------------
    mode_t start_mode;
    assign start_mode = norm_mode(mode);

    always_comb begin
        state_next    = state_reg;
        mode_next     = mode_reg;
        period_next   = period_reg;
        passes_next   = passes_reg;
        pass_cnt_next = pass_cnt_reg;
        pos_next      = pos_reg;
        dir_up_next   = dir_up_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_next    = ST_RUN;
                    mode_next     = start_mode;
                    period_next   = period;
                    passes_next   = passes;
                    pass_cnt_next = '0;
                    dir_up_next   = 1'b1;
                    pos_next      = (start_mode == MODE_WRAP_DOWN) ? POS_LAST : '0;
                end
            end
            ST_RUN: begin
                // stop wins over a step, including the pass-completing one.
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (tick) begin
                    pos_next    = step_pos;
                    dir_up_next = step_dir_up;
                    if (step_pass) begin
                        pass_cnt_next = pass_cnt_inc;
                        if (last_pass) begin
                            state_next = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            mode_reg     <= MODE_BOUNCE;
            period_reg   <= '0;
            passes_reg   <= '0;
            pass_cnt_reg <= '0;
            pos_reg      <= '0;
            dir_up_reg   <= 1'b1;
        end else begin
            state_reg    <= state_next;
            mode_reg     <= mode_next;
            period_reg   <= period_next;
            passes_reg   <= passes_next;
            pass_cnt_reg <= pass_cnt_next;
            pos_reg      <= pos_next;
            dir_up_reg   <= dir_up_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all decoded from registered state, so reset clears them at once.
    // -------------------------------------------------------------------------
    logic lit;

    assign busy = (state_reg == ST_RUN);
    assign done = (state_reg == ST_DONE);
    assign pos  = pos_reg;
    assign lit  = (state_reg == ST_RUN) || (state_reg == ST_DONE);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_led
            assign led_out[gi] = lit && (pos_reg == POS_W'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_night_rider_ctrl.sv
// -----------------------------------------------------------------------------
// tb_night_rider_ctrl
//   Directed scenarios for night_rider_ctrl (N = 8). Stimulus pushes the
//   expected per-cycle outputs into a scoreboard queue tagged with the cycle
//   number; a monitor on the falling edge pops and compares every entry whose
//   cycle has arrived. Cycle k of a scenario is the k-th cycle after the one
//   in which start was driven.
// -----------------------------------------------------------------------------
module tb_night_rider_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [15:0] period;
    logic [7:0]  passes;
    logic        busy;
    logic        done;
    logic [2:0]  pos;
    logic [7:0]  led_out;

    night_rider_ctrl #(
        .N      (8),
        .PW     (16),
        .PASS_W (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .period  (period),
        .passes  (passes),
        .busy    (busy),
        .done    (done),
        .pos     (pos),
        .led_out (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         chk_pos;
        logic       busy;
        logic       done;
        logic [2:0] pos;
        logic [7:0] led;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s cyc=%0d: expectation for cyc %0d never sampled", e.tag, cyc, e.cyc);
            end else if (busy !== e.busy || done !== e.done || led_out !== e.led ||
                         (e.chk_pos && pos !== e.pos)) begin
                errors++;
                $display("FAIL %s cyc=%0d got busy=%b done=%b pos=%0d led=%h required busy=%b done=%b pos=%0d led=%h",
                         e.tag, cyc, busy, done, pos, led_out, e.busy, e.done, e.pos, e.led);
            end else begin
                $display("ok   %s cyc=%0d busy=%b done=%b pos=%0d led=%h",
                         e.tag, cyc, busy, done, pos, led_out);
            end
        end
    end

    // ---------------- expectation helpers ----------------
    task automatic push(input int c, input bit cp, input logic b, input logic d,
                        input int p, input int l, input string t);
        exp_t x;
        x.cyc = c; x.chk_pos = cp; x.busy = b; x.done = d;
        x.pos = 3'(p); x.led = 8'(l); x.tag = t;
        sb.push_back(x);
    endtask

    // Position after s steps, closed form for N = 8.
    function automatic int bounce_pos(input int s);
        int i;
        i = s % 14;
        return (i <= 7) ? i : 14 - i;
    endfunction

    function automatic int run_pos(input int m, input int s);
        case (m)
            1:       return s % 8;
            2:       return 7 - (s % 8);
            default: return bounce_pos(s);
        endcase
    endfunction

    // Running cycles 1..run_cycles; if done_steps > 0 also the done cycle and
    // the idle cycle after it.
    task automatic push_run(input int base, input int m, input int per,
                            input int done_steps, input int run_cycles, input string t);
        int p;
        int kd;
        for (int k = 1; k <= run_cycles; k++) begin
            p = run_pos(m, (k - 1) / (per + 1));
            push(base + k, 1'b1, 1'b1, 1'b0, p, 1 << p, t);
        end
        if (done_steps > 0) begin
            kd = 1 + done_steps * (per + 1);
            p  = run_pos(m, done_steps);
            push(base + kd,     1'b1, 1'b0, 1'b1, p, 1 << p, t);
            push(base + kd + 1, 1'b0, 1'b0, 1'b0, 0, 0, t);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a one-cycle start pulse in the current cycle.
    task automatic pulse_start(input logic [1:0] m, input int per, input int pas, output int base);
        base   = cyc;
        mode   = m;
        period = 16'(per);
        passes = 8'(pas);
        start  = 1'b1;
        goto(base + 1);
        start  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int base;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        mode   = 2'b00;
        period = '0;
        passes = '0;

        // Reset state
        push(1, 1'b1, 1'b0, 1'b0, 0, 0, "reset");
        push(2, 1'b1, 1'b0, 1'b0, 0, 0, "reset");
        goto(3);
        rst_n = 1'b1;
        goto(5);

        // Bounce, period 0, one pass: done in cycle 14*1+1 = 15, pos 0
        base = cyc;
        push_run(base, 0, 0, 14, 14, "bounce_p0");
        pulse_start(2'b00, 0, 1, base);
        goto(base + 18);

        // Wrap-up, period 1, two passes: done in cycle 33 with pos 0.
        // Inputs changed and start pulsed mid-run must not disturb it.
        base = cyc;
        push_run(base, 1, 1, 16, 32, "wrapup_p1");
        pulse_start(2'b01, 1, 2, base);
        goto(base + 5);
        mode = 2'b10; period = 16'd3; passes = 8'd0; start = 1'b1;
        goto(base + 6);
        start = 1'b0;
        goto(base + 36);

        // Wrap-down, period 0, one pass: done in cycle 9 with pos 7, led 0x80
        base = cyc;
        push_run(base, 2, 0, 8, 8, "wrapdown");
        pulse_start(2'b10, 0, 1, base);
        goto(base + 12);

        // Endless bounce, stop in cycle 40: idle from 41, pos holds at 3
        base = cyc;
        push_run(base, 0, 0, 0, 40, "endless");
        push(base + 41, 1'b1, 1'b0, 1'b0, 3, 0, "endless_stop");
        push(base + 42, 1'b1, 1'b0, 1'b0, 3, 0, "endless_stop");
        pulse_start(2'b00, 0, 0, base);
        goto(base + 40);
        stop = 1'b1;
        goto(base + 41);
        stop = 1'b0;
        goto(base + 44);

        // start and stop together in IDLE: stays idle, pos still 3
        base = cyc;
        push(base + 1, 1'b1, 1'b0, 1'b0, 3, 0, "start_stop_idle");
        push(base + 2, 1'b1, 1'b0, 1'b0, 3, 0, "start_stop_idle");
        start = 1'b1; stop = 1'b1; mode = 2'b00; period = '0; passes = 8'd1;
        goto(base + 1);
        start = 1'b0; stop = 1'b0;
        goto(base + 4);

        // stop in the completing cycle (14): no done, pos holds at 1
        base = cyc;
        push_run(base, 0, 0, 0, 14, "stop_at_end");
        push(base + 15, 1'b1, 1'b0, 1'b0, 1, 0, "stop_at_end");
        push(base + 16, 1'b1, 1'b0, 1'b0, 1, 0, "stop_at_end");
        pulse_start(2'b00, 0, 1, base);
        goto(base + 14);
        stop = 1'b1;
        goto(base + 15);
        stop = 1'b0;
        goto(base + 18);

        // Reset in cycle 5 of a run: outputs at reset values in that cycle
        base = cyc;
        push_run(base, 0, 0, 0, 4, "midrun_reset");
        push(base + 5, 1'b1, 1'b0, 1'b0, 0, 0, "midrun_reset");
        push(base + 6, 1'b1, 1'b0, 1'b0, 0, 0, "midrun_reset");
        push(base + 7, 1'b1, 1'b0, 1'b0, 0, 0, "midrun_reset");
        pulse_start(2'b00, 0, 1, base);
        goto(base + 5);
        rst_n = 1'b0;
        goto(base + 7);
        rst_n = 1'b1;
        goto(base + 9);

        // After reset: reserved mode 11 runs as bounce, period 2, one pass.
        // Done at cycle 1 + 14*3 = 43 with pos 0.
        base = cyc;
        push_run(base, 3, 2, 14, 42, "reserved_p2");
        pulse_start(2'b11, 2, 1, base);
        goto(base + 46);

        // Drain the scoreboard with a bound
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time bound at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
